// File: rtl/tc_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// tc_mul_share_arbiter
//
// Purpose:
//   Round-robin arbiter that time-shares one external signed 16x15 -> 30-bit
//   combinational multiplier among NREQ requesters. One requester is granted
//   per cycle. Its operands are registered into stage S1, which drives the
//   multiplier directly. The product is then captured into stage S2 together
//   with the owning requester's index. Both stages stall together when a
//   result is present and the consumer is not ready.
//
// Ports:
//   ap_clk     in   1        clock, rising edge
//   ap_rst     in   1        synchronous active-high reset
//   req_valid  in   NREQ     requester i offers an operand pair
//   req_ready  out  NREQ     requester i's pair is accepted this cycle (one-hot or zero)
//   req_a      in   NREQ*16  signed multiplicand of requester i in [16i+15:16i]
//   req_b      in   NREQ*15  signed multiplier of requester i in [15i+14:15i]
//   mul_din0   out  16       operand A to the shared multiplier (registered)
//   mul_din1   out  15       operand B to the shared multiplier (registered)
//   mul_dout   in   30       product from the shared multiplier, zero latency
//   res_valid  out  1        result present
//   res_ready  in   1        consumer accepts the result
//   res_id     out  IDW      index of the requester owning the result
//   res_p      out  30       signed product (low 30 bits, wraps silently)
// ---------------------------------------------------------------------------
module tc_mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*15-1:0]   req_b,
    output logic [15:0]          mul_din0,
    output logic [14:0]          mul_din1,
    input  logic [29:0]          mul_dout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [29:0]          res_p
);

    // After reset the pointer sits on the last requester so requester 0
    // is searched first.
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
    // Requester count in the one-bit-wider search width, used for wrapping.
    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

    // Stage S1: accepted operands feeding the multiplier.
    logic                s1_valid_r;
    logic [15:0]         s1_a_r;
    logic [14:0]         s1_b_r;
    logic [IDW-1:0]      s1_id_r;

    // Stage S2: captured product and owner.
    logic                res_valid_r;
    logic [29:0]         res_p_r;
    logic [IDW-1:0]      res_id_r;

    // Round-robin pointer: index of the most recent winner.
    logic [IDW-1:0]      last_r;

    logic                adv_s;
    logic                found_s;
    logic [IDW-1:0]      winner_s;
    logic                accept_s;
    logic [15:0]         a_sel_s;
    logic [14:0]         b_sel_s;

    // Pipeline may move when S2 is empty or is being drained this cycle.
    always_comb begin
        adv_s    = (!res_valid_r) || res_ready;
        accept_s = adv_s && found_s;
    end

    // Round-robin search starting at last+1, wrapping modulo NREQ.
    // The candidate index is one bit wider so last+k never overflows
    // before the single wrap subtraction.
    always_comb begin : arb_search
        logic [IDW:0] cand_v;
        found_s  = 1'b0;
        winner_s = '0;
        cand_v   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_v = {1'b0, last_r} + (IDW + 1)'(k);
            if (cand_v >= NREQ_W) begin
                cand_v = cand_v - NREQ_W;
            end else begin
                cand_v = cand_v;
            end
            if (!found_s && req_valid[cand_v[IDW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_v[IDW-1:0];
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    // Grant vector: only the winner, only when the pipeline advances,
    // never while reset is asserted.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!ap_rst && accept_s && (winner_s == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Operand mux selecting the winner's pair with constant slice offsets.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_s == IDW'(i)) begin
                a_sel_s = req_a[i*16 +: 16];
                b_sel_s = req_b[i*15 +: 15];
            end else begin
                a_sel_s = a_sel_s;
                b_sel_s = b_sel_s;
            end
        end
    end

    // S1, S2 and pointer registers; everything holds while stalled.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= 16'd0;
            s1_b_r      <= 15'd0;
            s1_id_r     <= '0;
            res_valid_r <= 1'b0;
            res_p_r     <= 30'd0;
            res_id_r    <= '0;
            last_r      <= LAST_RST;
        end else if (adv_s) begin
            res_valid_r <= s1_valid_r;
            res_p_r     <= mul_dout;
            res_id_r    <= s1_id_r;
            s1_valid_r  <= found_s;
            if (found_s) begin
                s1_a_r  <= a_sel_s;
                s1_b_r  <= b_sel_s;
                s1_id_r <= winner_s;
                last_r  <= winner_s;
            end
        end
    end

    // Multiplier operands and results come straight from registers.
    always_comb begin
        mul_din0  = s1_a_r;
        mul_din1  = s1_b_r;
        res_valid = res_valid_r;
        res_p     = res_p_r;
        res_id    = res_id_r;
    end

endmodule

// File: tb/tb_tc_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tc_mul_share_arbiter
//
// Directed bench for tc_mul_share_arbiter (NREQ=4). Models the external
// multiplier as a signed product truncated to 30 bits and checks arithmetic
// vectors, round-robin order, backpressure, sparse requests with pointer
// hold, and reset while operations are in flight.
// ---------------------------------------------------------------------------
module tb_tc_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*15-1:0]   req_b;
    logic [15:0]          mul_din0;
    logic [14:0]          mul_din1;
    logic [29:0]          mul_dout;
    logic                 res_valid;
    logic                 res_ready;
    logic [IDW-1:0]       res_id;
    logic [29:0]          res_p;

    logic signed [30:0]   prod_full;

    int n_cmp = 0;
    int n_bad = 0;

    tc_mul_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p)
    );

    always #5 ap_clk = ~ap_clk;

    // External combinational multiplier.
    assign prod_full = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout  = prod_full[29:0];

    typedef struct {
        int id;
        int a;
        int b;
        int p;
    } vec_t;

    typedef struct {
        logic [3:0] valid;
        logic       rr;
        logic [3:0] exp_ready;
        logic       exp_rv;
        int         exp_id;
    } cyc_t;

    vec_t vec_tab[8];
    cyc_t cyc_tab[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] p32(input int p);
        return {2'b00, p[29:0]};
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst    = 1'b1;
        req_valid = 4'b0000;
        tick();
        tick();
        ap_rst    = 1'b0;
    endtask

    task automatic set_rot_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'(i + 1);
            req_b[15*i +: 15] = 15'd10;
        end
    endtask

    // One isolated request through the pipeline.
    task automatic run_vec(input vec_t v);
        logic [3:0] onehot;
        int         av;
        int         bv;
        onehot = 4'b0001 << v.id;
        av     = v.a;
        bv     = v.b;
        req_a[16*v.id +: 16] = av[15:0];
        req_b[15*v.id +: 15] = bv[14:0];
        req_valid = onehot;
        res_ready = 1'b1;
        #1;
        chk("vec_ready", 32'(req_ready), 32'(onehot));
        tick();
        req_valid = 4'b0000;
        chk("vec_s1_not_out", 32'(res_valid), 32'd0);
        tick();
        chk("vec_valid", 32'(res_valid), 32'd1);
        chk("vec_id", 32'(res_id), 32'(v.id));
        chk("vec_p", {2'b00, res_p}, p32(v.p));
        tick();
        chk("vec_valid_drop", 32'(res_valid), 32'd0);
    endtask

    // Cycle-by-cycle table: inputs before the edge, grant checked before
    // the edge, result checked after it.
    task automatic run_cycles(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            req_valid = cyc_tab[c].valid;
            res_ready = cyc_tab[c].rr;
            #1;
            chk($sformatf("cyc%0d_ready", c), 32'(req_ready), 32'(cyc_tab[c].exp_ready));
            tick();
            chk($sformatf("cyc%0d_rv", c), 32'(res_valid), 32'(cyc_tab[c].exp_rv));
            if (cyc_tab[c].exp_rv) begin
                chk($sformatf("cyc%0d_id", c), 32'(res_id), 32'(cyc_tab[c].exp_id));
                chk($sformatf("cyc%0d_p", c), {2'b00, res_p}, p32(10 * (cyc_tab[c].exp_id + 1)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_tab[0] = '{0, 100, -3, -300};
        vec_tab[1] = '{1, -32768, -16384, -536870912};
        vec_tab[2] = '{2, 32767, -16384, -536854528};
        vec_tab[3] = '{3, 0, -77, 0};
        vec_tab[4] = '{0, -7, 9, -63};
        vec_tab[5] = '{1, 32767, 16383, 536821761};
        vec_tab[6] = '{2, -32768, 16383, -536838144};
        vec_tab[7] = '{3, 123, 45, 5535};

        // Rotation: entries 0..9.
        cyc_tab[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 0};
        cyc_tab[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
        cyc_tab[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1};
        cyc_tab[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2};
        cyc_tab[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3};
        cyc_tab[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
        cyc_tab[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1};
        cyc_tab[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2};
        cyc_tab[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 3};
        cyc_tab[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
        // Backpressure: entries 10..21, res_ready low for cycles 5..7.
        cyc_tab[10] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 0};
        cyc_tab[11] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
        cyc_tab[12] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1};
        cyc_tab[13] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2};
        cyc_tab[14] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3};
        cyc_tab[15] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 3};
        cyc_tab[16] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 3};
        cyc_tab[17] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 3};
        cyc_tab[18] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
        cyc_tab[19] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1};
        cyc_tab[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2};
        cyc_tab[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};

        // Reset state, with requests pending to prove the grant is gated.
        ap_rst    = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        chk("rst_ready_after_edges", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_p", {2'b00, res_p}, 32'd0);
        chk("rst_din0", 32'(mul_din0), 32'd0);
        chk("rst_din1", 32'(mul_din1), 32'd0);
        req_valid = 4'b0000;
        ap_rst    = 1'b0;

        // Arithmetic and single-request latency.
        for (int i = 0; i < 8; i++) begin
            run_vec(vec_tab[i]);
        end

        // Rotation.
        do_reset();
        set_rot_ops();
        run_cycles(0, 9);

        // Backpressure.
        do_reset();
        run_cycles(10, 21);

        // Sparse requests and pointer hold across an idle cycle.
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("sparse_ready2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("sparse_idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("sparse_rv2", 32'(res_valid), 32'd1);
        chk("sparse_id2", 32'(res_id), 32'd2);
        chk("sparse_p2", {2'b00, res_p}, p32(30));
        req_valid = 4'b1010;
        #1;
        chk("sparse_ready3", 32'(req_ready), 32'b1000);
        tick();
        chk("sparse_bubble", 32'(res_valid), 32'd0);
        #1;
        chk("sparse_ready1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        chk("sparse_id3", 32'(res_id), 32'd3);
        chk("sparse_p3", {2'b00, res_p}, p32(40));
        tick();
        chk("sparse_rv1", 32'(res_valid), 32'd1);
        chk("sparse_id1", 32'(res_id), 32'd1);
        chk("sparse_p1", {2'b00, res_p}, p32(20));
        tick();
        chk("sparse_drain", 32'(res_valid), 32'd0);

        // Reset with two operations in flight; pointer currently at 1.
        req_valid = 4'b1111;
        tick();
        tick();
        chk("mid_inflight", 32'(res_valid), 32'd1);
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        chk("mid_rst_rv", 32'(res_valid), 32'd0);
        chk("mid_rst_id", 32'(res_id), 32'd0);
        chk("mid_rst_p", {2'b00, res_p}, 32'd0);
        chk("mid_rst_din0", 32'(mul_din0), 32'd0);
        chk("mid_rst_din1", 32'(mul_din1), 32'd0);
        ap_rst = 1'b0;
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        chk("mid_no_stale", 32'(res_valid), 32'd0);
        tick();
        chk("mid_new_rv", 32'(res_valid), 32'd1);
        chk("mid_new_id", 32'(res_id), 32'd0);
        chk("mid_new_p", {2'b00, res_p}, p32(10));
        tick();
        chk("mid_done", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
